// File: rtl/stoch_operand_tx.sv
// Dual-channel framed serial transmitter for stochastic-multiplier operands.
// Latency: guard bit on the cycle after acceptance, data LSB-first over the next 9.
// Backpressure: one-deep pending buffer; in_ready low while it holds a pair.
module stoch_operand_tx #(
    parameter int unsigned FRAME_PERIOD = 131072,
    parameter logic [8:0]  CLAMP_LO     = 9'h000,
    parameter logic [8:0]  CLAMP_HI     = 9'h1FF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_a,
    input  logic [8:0] in_b,
    input  logic       repeat_en,
    output logic       tx_a,
    output logic       tx_b,
    output logic       frame_start,
    output logic       busy
);

    localparam int unsigned   PW        = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(FRAME_PERIOD - 1);
    localparam logic [3:0]    SLOT_LAST = 4'd9;

    typedef struct packed {
        logic [8:0] a;
        logic [8:0] b;
    } pair_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    slot_q, slot_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    pair_t         cur_q, cur_d;
    pair_t         pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic          tx_a_d, tx_b_d, fs_d, busy_d;
    logic          xfer;
    pair_t         in_clamped;
    logic [3:0]    bit_idx;

    function automatic logic [8:0] clamp(input logic [8:0] x);
        logic [8:0] y;
        y = (x < CLAMP_LO) ? CLAMP_LO : x;
        return (y > CLAMP_HI) ? CLAMP_HI : y;
    endfunction

    assign in_ready   = !pend_v_q;
    assign xfer       = in_valid && !pend_v_q;
    assign in_clamped = {clamp(in_a), clamp(in_b)};

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        pcnt_d   = pcnt_q;
        cur_d    = cur_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;

        case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    cur_d    = pend_q;
                    pend_v_d = 1'b0;
                    state_d  = SEND;
                    slot_d   = 4'd0;
                    pcnt_d   = '0;
                end else if (xfer) begin
                    cur_d   = in_clamped;
                    state_d = SEND;
                    slot_d  = 4'd0;
                    pcnt_d  = '0;
                end
            end
            SEND: begin
                pcnt_d = pcnt_q + 1'b1;
                slot_d = slot_q + 4'd1;
                if (slot_q == SLOT_LAST) begin
                    state_d = GAP;
                    slot_d  = 4'd0;
                end
                if (xfer) begin
                    pend_d   = in_clamped;
                    pend_v_d = 1'b1;
                end
            end
            GAP: begin
                if (pcnt_q == PCNT_LAST) begin
                    // Pending pair beats a same-edge transfer, which beats repeat.
                    if (pend_v_q) begin
                        cur_d    = pend_q;
                        pend_v_d = 1'b0;
                        state_d  = SEND;
                    end else if (xfer) begin
                        cur_d   = in_clamped;
                        state_d = SEND;
                    end else if (repeat_en) begin
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                    slot_d = 4'd0;
                    pcnt_d = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                    if (xfer) begin
                        pend_d   = in_clamped;
                        pend_v_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                slot_d  = 4'd0;
                pcnt_d  = '0;
            end
        endcase
    end

    // Line values are computed from the next state so the pins come straight off flops.
    always_comb begin
        bit_idx = slot_d - 4'd1;
        tx_a_d  = 1'b0;
        tx_b_d  = 1'b0;
        fs_d    = (state_d == SEND) && (slot_d == 4'd0);
        busy_d  = (state_d != IDLE);
        if ((state_d == SEND) && (slot_d != 4'd0)) begin
            tx_a_d = cur_d.a[bit_idx];
            tx_b_d = cur_d.b[bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            slot_q      <= 4'd0;
            pcnt_q      <= '0;
            cur_q       <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            tx_a        <= 1'b0;
            tx_b        <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            pcnt_q      <= pcnt_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            tx_a        <= tx_a_d;
            tx_b        <= tx_b_d;
            frame_start <= fs_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_stoch_operand_tx.sv
// Scoreboard bench: stimulus queues expected frames and signal probes; one monitor checks them.
module tb_stoch_operand_tx;

    localparam int FP = 16;

    logic       clk;
    logic       rst_n;
    logic       v0, v1, rep0, rep1;
    logic [8:0] a0, b0, a1, b1;
    logic [1:0] rdy_v, tx_a_v, tx_b_v, fs_v, busy_v;

    typedef struct packed {
        int d;
        int sig;
        int exp;
        int val;
    } probe_t;

    logic [17:0] exp_q0[$];
    logic [17:0] exp_q1[$];
    probe_t      pq[$];
    string       nq[$];

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         slot [2];
    int         last_fs [2];
    logic       prev_busy [2];
    logic [8:0] sh_a [2];
    logic [8:0] sh_b [2];

    stoch_operand_tx #(.FRAME_PERIOD(FP)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy_v[0]),
        .in_a(a0), .in_b(b0), .repeat_en(rep0),
        .tx_a(tx_a_v[0]), .tx_b(tx_b_v[0]), .frame_start(fs_v[0]), .busy(busy_v[0])
    );

    stoch_operand_tx #(.FRAME_PERIOD(FP), .CLAMP_LO(9'h0F1), .CLAMP_HI(9'h10F)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy_v[1]),
        .in_a(a1), .in_b(b1), .repeat_en(rep1),
        .tx_a(tx_a_v[1]), .tx_b(tx_b_v[1]), .frame_start(fs_v[1]), .busy(busy_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: evaluates probes, deserializes frames, and checks quiet lines between frames.
    always begin
        probe_t      pr;
        string       nm;
        logic [31:0] act;
        logic [17:0] e;
        @(negedge clk);
        cyc++;
        while (pq.size() > 0) begin
            pr = pq.pop_front();
            nm = nq.pop_front();
            case (pr.sig)
                0:       act = 32'(rdy_v[pr.d]);
                1:       act = 32'(busy_v[pr.d]);
                2:       act = 32'(tx_a_v[pr.d]);
                3:       act = 32'(tx_b_v[pr.d]);
                4:       act = 32'(fs_v[pr.d]);
                5:       act = (pr.d == 0) ? exp_q0.size() : exp_q1.size();
                default: act = pr.val;
            endcase
            check(nm, act, pr.exp);
        end
        for (int d = 0; d < 2; d++) begin
            if (rst_n) begin
                slot[d]      = -1;
                prev_busy[d] = 1'b0;
            end else begin
                if (fs_v[d]) begin
                    check("guard_bit", 32'({tx_a_v[d], tx_b_v[d]}), 0);
                    if (prev_busy[d])
                        check("frame_spacing", cyc - last_fs[d], FP);
                    last_fs[d] = cyc;
                    slot[d]    = 0;
                end else if (slot[d] >= 0) begin
                    sh_a[d][slot[d]] = tx_a_v[d];
                    sh_b[d][slot[d]] = tx_b_v[d];
                    slot[d]++;
                    if (slot[d] == 9) begin
                        slot[d] = -1;
                        check("frame_expected", ((d == 0 ? exp_q0.size() : exp_q1.size()) > 0) ? 1 : 0, 1);
                        if ((d == 0 ? exp_q0.size() : exp_q1.size()) > 0) begin
                            if (d == 0) e = exp_q0.pop_front();
                            else        e = exp_q1.pop_front();
                            check(d == 0 ? "dut0_word_a" : "dut1_word_a", 32'(sh_a[d]), 32'(e[17:9]));
                            check(d == 0 ? "dut0_word_b" : "dut1_word_b", 32'(sh_b[d]), 32'(e[8:0]));
                        end
                    end
                end else begin
                    check("line_quiet", 32'({tx_a_v[d], tx_b_v[d]}), 0);
                end
                prev_busy[d] = busy_v[d];
            end
        end
    end

    task automatic probe(input int d, input int sig, input int exp, input string nm);
        pq.push_back('{d: d, sig: sig, exp: exp, val: 0});
        nq.push_back(nm);
    endtask

    task automatic push_exp(input int d, input logic [8:0] a, input logic [8:0] b);
        if (d == 0) exp_q0.push_back({a, b});
        else        exp_q1.push_back({a, b});
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers a pair and returns #1 after the accepting edge (bounded wait).
    task automatic send(input int d, input logic [8:0] a, input logic [8:0] b);
        logic ok;
        logic r;
        ok = 1'b0;
        if (d == 0) begin v0 = 1'b1; a0 = a; b0 = b; end
        else        begin v1 = 1'b1; a1 = a; b1 = b; end
        for (int k = 0; k < 40; k++) begin
            r = rdy_v[d];
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
            #1;
        end
        #1;
        if (d == 0) v0 = 1'b0;
        else        v1 = 1'b0;
        pq.push_back('{d: d, sig: 6, exp: 1, val: int'(ok)});
        nq.push_back("handshake_accepted");
    endtask

    initial begin
        rst_n = 1'b1;
        v0 = 1'b0; v1 = 1'b0; rep0 = 1'b0; rep1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        probe(0, 0, 1, "reset_in_ready");
        probe(0, 1, 0, "reset_busy");
        probe(0, 4, 0, "reset_frame_start");
        probe(1, 0, 1, "reset_in_ready_d1");
        cyc_wait(2);

        // Single frame: 0x1A5 / 0x05A
        push_exp(0, 9'h1A5, 9'h05A);
        send(0, 9'h1A5, 9'h05A);
        probe(0, 4, 1, "single_fs_t1");
        probe(0, 1, 1, "single_busy_t1");
        cyc_wait(1);
        probe(0, 2, 1, "single_a_bit0");
        probe(0, 3, 0, "single_b_bit0");
        cyc_wait(8);
        probe(0, 2, 1, "single_a_bit8");
        probe(0, 3, 0, "single_b_bit8");
        cyc_wait(6);
        probe(0, 1, 1, "single_busy_last_gap");
        cyc_wait(1);
        probe(0, 1, 0, "single_busy_after");
        probe(0, 4, 0, "single_fs_after");
        cyc_wait(3);

        // Back-to-back: second pair accepted during GAP
        push_exp(0, 9'h033, 9'h1CC);
        push_exp(0, 9'h0F0, 9'h10F);
        send(0, 9'h033, 9'h1CC);
        cyc_wait(11);
        send(0, 9'h0F0, 9'h10F);
        probe(0, 0, 0, "b2b_ready_low");
        probe(0, 1, 1, "b2b_busy");
        cyc_wait(4);
        probe(0, 4, 1, "b2b_second_fs");
        probe(0, 0, 1, "b2b_ready_back");
        cyc_wait(1);
        probe(0, 2, 0, "b2b_a_bit0");
        probe(0, 3, 1, "b2b_b_bit0");
        cyc_wait(15);
        probe(0, 1, 0, "b2b_idle");
        cyc_wait(3);

        // Repeat: three identical frames, then stop
        rep0 = 1'b1;
        push_exp(0, 9'h155, 9'h0AA);
        push_exp(0, 9'h155, 9'h0AA);
        push_exp(0, 9'h155, 9'h0AA);
        send(0, 9'h155, 9'h0AA);
        cyc_wait(16);
        probe(0, 4, 1, "repeat_fs2");
        cyc_wait(16);
        probe(0, 4, 1, "repeat_fs3");
        cyc_wait(7);
        rep0 = 1'b0;
        cyc_wait(8);
        probe(0, 1, 1, "repeat_busy_last_gap");
        cyc_wait(1);
        probe(0, 1, 0, "repeat_idle");
        cyc_wait(3);

        // Priority: transfer on the final GAP edge beats repeat
        rep0 = 1'b1;
        push_exp(0, 9'h1E1, 9'h01E);
        push_exp(0, 9'h003, 9'h100);
        send(0, 9'h1E1, 9'h01E);
        cyc_wait(15);
        send(0, 9'h003, 9'h100);
        rep0 = 1'b0;
        probe(0, 0, 1, "prio_direct_to_cur");
        probe(0, 4, 1, "prio_fs");
        cyc_wait(16);
        probe(0, 1, 0, "prio_idle");
        cyc_wait(3);

        // Reset mid-SEND with a pending pair: nothing may be emitted afterwards
        send(0, 9'h1FF, 9'h1FF);
        send(0, 9'h0AA, 9'h0AA);
        probe(0, 0, 0, "rst_pend_full");
        rst_n = 1'b1;
        cyc_wait(3);
        rst_n = 1'b0;
        probe(0, 0, 1, "rst_mid_in_ready");
        probe(0, 1, 0, "rst_mid_busy");
        probe(0, 2, 0, "rst_mid_tx_a");
        probe(0, 3, 0, "rst_mid_tx_b");
        probe(0, 4, 0, "rst_mid_fs");
        cyc_wait(40);

        // Clamp window 0x0F1..0x10F on the second instance
        push_exp(1, 9'h10F, 9'h0F1);
        push_exp(1, 9'h100, 9'h0F1);
        push_exp(1, 9'h0F1, 9'h10F);
        send(1, 9'h1FF, 9'h000);
        send(1, 9'h100, 9'h0F0);
        send(1, 9'h0F1, 9'h10F);
        cyc_wait(40);

        probe(0, 5, 0, "dut0_frames_outstanding");
        probe(1, 5, 0, "dut1_frames_outstanding");
        cyc_wait(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stoch_operand_tx.md
# stoch_operand_tx

Dual-channel serial operand transmitter: the sending end of the serial operand link that feeds the stochastic multiplier's `ui_in[0]`/`ui_in[1]` bit deserializers. It accepts two 9-bit bipolar probability words over a valid/ready handshake. It optionally clamps each word, then emits both words simultaneously as framed, LSB-first bit streams. Frame starts are spaced exactly one accumulation window apart, so each new operand pair lines up with one multiplier output period.

## Interface
- `FRAME_PERIOD`, default 131072: cycles from one frame start to the next; must be ≥ 11.
- `CLAMP_LO`, default 9'h000: lower clamp bound applied to both operands.
- `CLAMP_HI`, default 9'h1FF: upper clamp bound applied to both operands; must be ≥ `CLAMP_LO`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-high (1 = reset), despite the name.
- `in_valid`  in  1  operand pair presented.
- `in_ready`  out  1  pair can be accepted this cycle.
- `in_a`  in  9  operand for channel A (drives multiplier `ui_in[0]`).
- `in_b`  in  9  operand for channel B (drives multiplier `ui_in[1]`).
- `repeat_en`  in  1  retransmit the last pair when no new pair is pending.
- `tx_a`  out  1  serial line A, registered.
- `tx_b`  out  1  serial line B, registered.
- `frame_start`  out  1  one-cycle pulse, high during slot 0 of every frame.
- `busy`  out  1  high in SEND or GAP.

## Operation
- Registers:
  - `cur_a`, `cur_b` (9b): pair being sent.
  - `pend_a`, `pend_b` (9b) plus `pend_v`: one-deep buffer.
  - Slot counter, 0..9.
  - Period counter, ceil(log2(FRAME_PERIOD)) bits.
  - State: IDLE, SEND, GAP.
- Handshake:
  - `in_ready = !pend_v`, combinational.
  - A transfer occurs on any rising edge where `in_valid && in_ready`.
  - Clamping is applied at transfer: value = min(max(x, CLAMP_LO), CLAMP_HI), unsigned compare.
- IDLE:
  - `tx_a = tx_b = 0`.
  - On transfer, load the clamped pair directly into `cur`, bypassing `pend`; go to SEND, slot 0.
  - If `pend_v` is set on entry (not possible with normal flow), load from `pend` and clear it.
- SEND (10 cycles):
  - Slot 0 is the guard bit: `tx = 0`, `frame_start = 1`.
  - Slot k, k = 1..9, carries `cur[k-1]`, LSB first.
  - After slot 9, go to GAP.
- GAP:
  - `tx = 0` for `FRAME_PERIOD-10` cycles.
  - Transfers during SEND or GAP land in `pend`.
  - On the last GAP cycle, the next state is chosen in priority order:
    1. `pend_v`: move `pend` → `cur`, clear `pend_v`, SEND.
    2. `repeat_en`: SEND with unchanged `cur`.
    3. Otherwise: IDLE.
- Simultaneous events:
  - A transfer on the same edge that GAP ends with `pend_v = 0`: the new pair goes directly to `cur`, sent next frame.
  - It takes priority over repeat.
- `repeat_en` is sampled only on the last GAP cycle.
- Reset (any state, mid-frame included): on the next edge, state = IDLE, `tx_a = tx_b = 0`, `frame_start = 0`, `busy = 0`, `pend_v = 0`, `cur = 0`, counters = 0. `in_ready` is 1 after reset.

## Timing
- Transfer in IDLE at edge T:
  - `frame_start` and the guard bit appear in cycle T+1.
  - Data bit 0 in T+2, bit 8 in T+10.
  - First GAP cycle is T+11.
- Back-to-back frames: successive `frame_start` pulses are exactly `FRAME_PERIOD` cycles apart, with no idle cycle inserted.
- `busy` is high from T+1 until the cycle after the last GAP cycle of the final frame.
- `in_ready` drops the cycle after a transfer into `pend`. It returns to 1 in the first SEND cycle that consumes `pend`.
- All outputs except `in_ready` are registered; no combinational path from inputs to `tx_*`.

## Test plan
- Reset: hold `rst_n = 1` for 3 cycles mid-SEND, then release → `tx_a = tx_b = frame_start = busy = 0`, `in_ready = 1`, state IDLE, and no residual bits are emitted.
- Single frame (FRAME_PERIOD = 16): send `in_a = 0x1A5`, `in_b = 0x05A` at edge T.
  - `tx_a` over T+1..T+10 = 0,1,0,1,0,0,1,0,1,1.
  - `tx_b` over T+1..T+10 = 0,0,1,0,1,1,0,1,0,0.
  - Both lines stay 0 through T+16; then IDLE, `busy = 0`.
- Back-to-back (FRAME_PERIOD = 16): second pair 0x0F0/0x10F presented during GAP → `in_ready` = 0 after transfer; second `frame_start` at T+17, exactly 16 after the first; second pair bits correct.
- Repeat: `repeat_en = 1`, one pair 0x155/0x0AA, no further input → identical frames with `frame_start` every 16 cycles. Drop `repeat_en` → IDLE after the current GAP.
- Clamp: CLAMP_LO = 0x0F1, CLAMP_HI = 0x10F.
  - Input 0x1FF/0x000 → serialized values 0x10F/0x0F1.
  - Input 0x100 → 0x100 unchanged.
- Priority: on the final GAP edge, assert a transfer of 0x003 with `repeat_en = 1` and `pend_v = 0` → next frame carries 0x003, not the previous operand.
